// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU sequencer: instruction field positions,
// opcodes, ARM-style condition codes and the sequencer state encoding.
package cpu_pkg;

    // Instruction word layout: {cond, opcode, S, unused, IV_Mov, unused}
    localparam int COND_MSB = 31;
    localparam int COND_LSB = 28;
    localparam int OP_MSB   = 27;
    localparam int OP_LSB   = 24;
    localparam int S_BIT    = 23;
    localparam int IV_MSB   = 18;
    localparam int IV_LSB   = 3;
    localparam int IV_W     = IV_MSB - IV_LSB + 1;

    // Bit positions inside the {N,Z,C,V} flag nibble
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Opcodes 0x0..0xB are plain ALU operations
    localparam logic [3:0] OP_LDR  = 4'hC;
    localparam logic [3:0] OP_STR  = 4'hD;
    localparam logic [3:0] OP_B    = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEM       = 3'd4,
        WRITEBACK = 3'd5,
        HALT      = 3'd6
    } state_t;

    // Data-RAM instructions take the MEM detour
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LDR) || (op == OP_STR);
    endfunction

    // Only ALU operations may update the architectural flags
    function automatic logic sets_flags(input logic [3:0] op);
        return (op != OP_LDR) && (op != OP_STR) && (op != OP_B) && (op != OP_HALT);
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Memory-side bus of the sequencer: instruction-RAM fetch port and
// data-RAM access port.
//
// Handshake: the requester raises Req (with address / direction stable) in
// the state that needs the access and holds it unchanged until it samples
// Ack high on a rising clock edge; the transfer completes on that edge and
// Req drops in the following state. Ack is only meaningful while the
// matching Req is high; an Ack seen at any other time is ignored.
interface cpu_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic              Ins_Req;
    logic [ADDR_W-1:0] Ins_Addr;
    logic [31:0]       Ins_Data;
    logic              Ins_Ack;
    logic              Mem_Req;
    logic              Mem_RW;
    logic              Mem_Ack;

    modport master (
        output Ins_Req, Ins_Addr, Mem_Req, Mem_RW,
        input  Ins_Data, Ins_Ack, Mem_Ack
    );

    modport slave (
        input  Ins_Req, Ins_Addr, Mem_Req, Mem_RW,
        output Ins_Data, Ins_Ack, Mem_Ack
    );
endinterface

// File: rtl/cond_check.sv
// Combinational ARM-style condition evaluator: (cond, {N,Z,C,V}) -> pass.
module cond_check
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flag,
    output logic       pass
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = flag[FLAG_N];
    assign z = flag[FLAG_Z];
    assign c = flag[FLAG_C];
    assign v = flag[FLAG_V];

    // Map each condition code onto its flag expression
    always_comb begin
        pass = 1'b0;
        case (cond_t'(cond))
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control unit: owns the PC, fetches and latches instructions,
// evaluates the condition field and steps ALU, write-back and data-RAM
// accesses through a fixed FSM.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Run,
    cpu_sequencer_if.master   bus,
    output logic [31:0]       Instr,
    output logic              Alu_En,
    input  logic [3:0]        New_Flag,
    output logic [3:0]        Flag,
    output logic              Reg_WE,
    output logic [ADDR_W-1:0] PC,
    output logic              Halted,
    output logic              Busy,
    output state_t            Dbg_State
);

    state_t            state;
    state_t            state_nx;
    state_t            after_instr;
    logic [ADDR_W-1:0] pc_nx;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] br_target;
    logic [31:0]       instr_nx;
    logic [3:0]        flag_nx;
    logic              stop_req;
    logic              stop_req_nx;
    logic              run_low_seen;
    logic              run_low_seen_nx;

    logic [3:0]        cond;
    logic [3:0]        opcode;
    logic              s_bit;
    logic              cond_pass;

    logic              ins_req;
    logic              mem_req;
    logic              mem_rw;
    logic              alu_en;
    logic              reg_we;

    assign cond      = Instr[COND_MSB:COND_LSB];
    assign opcode    = Instr[OP_MSB:OP_LSB];
    assign s_bit     = Instr[S_BIT];
    assign pc_inc    = PC + ADDR_W'(1);
    // Absolute branch target, zero-extended or truncated to the PC width
    assign br_target = ADDR_W'(Instr[IV_MSB:IV_LSB]);

    // A Run drop seen at any point of an instruction parks the FSM in IDLE
    // once that instruction has finished instead of fetching the next one.
    assign after_instr = (stop_req || !Run) ? IDLE : FETCH;

    cond_check u_cond_check (
        .cond (cond),
        .flag (Flag),
        .pass (cond_pass)
    );

    // Next-state, datapath updates and per-state strobes
    always_comb begin
        state_nx        = state;
        pc_nx           = PC;
        instr_nx        = Instr;
        flag_nx         = Flag;
        stop_req_nx     = stop_req;
        run_low_seen_nx = run_low_seen;
        ins_req         = 1'b0;
        mem_req         = 1'b0;
        mem_rw          = 1'b1;
        alu_en          = 1'b0;
        reg_we          = 1'b0;

        if ((state != IDLE) && (state != HALT) && !Run) begin
            stop_req_nx = 1'b1;
        end

        case (state)
            IDLE: begin
                stop_req_nx = 1'b0;
                if (Run) begin
                    state_nx = FETCH;
                end
            end
            FETCH: begin
                ins_req = 1'b1;
                if (bus.Ins_Ack) begin
                    instr_nx = bus.Ins_Data;
                    state_nx = DECODE;
                end
            end
            DECODE: begin
                if (!cond_pass) begin
                    pc_nx    = pc_inc;
                    state_nx = after_instr;
                end else if (opcode == OP_HALT) begin
                    state_nx = HALT;
                end else begin
                    state_nx = EXECUTE;
                end
            end
            EXECUTE: begin
                alu_en = 1'b1;
                if (s_bit && sets_flags(opcode)) begin
                    flag_nx = New_Flag;
                end
                if (opcode == OP_B) begin
                    pc_nx    = br_target;
                    state_nx = after_instr;
                end else if (is_mem_op(opcode)) begin
                    state_nx = MEM;
                end else begin
                    state_nx = WRITEBACK;
                end
            end
            MEM: begin
                alu_en  = 1'b1;
                mem_req = 1'b1;
                mem_rw  = (opcode == OP_LDR);
                if (bus.Mem_Ack) begin
                    if (opcode == OP_LDR) begin
                        state_nx = WRITEBACK;
                    end else begin
                        pc_nx    = pc_inc;
                        state_nx = after_instr;
                    end
                end
            end
            WRITEBACK: begin
                alu_en   = 1'b1;
                reg_we   = 1'b1;
                pc_nx    = pc_inc;
                state_nx = after_instr;
            end
            HALT: begin
                // Restart needs a full Run low-then-high cycle
                stop_req_nx = 1'b0;
                if (!Run) begin
                    run_low_seen_nx = 1'b1;
                end else if (run_low_seen) begin
                    run_low_seen_nx = 1'b0;
                    pc_nx           = pc_inc;
                    state_nx        = FETCH;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and architectural registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            PC           <= RESET_PC;
            Instr        <= '0;
            Flag         <= '0;
            stop_req     <= 1'b0;
            run_low_seen <= 1'b0;
        end else begin
            state        <= state_nx;
            PC           <= pc_nx;
            Instr        <= instr_nx;
            Flag         <= flag_nx;
            stop_req     <= stop_req_nx;
            run_low_seen <= run_low_seen_nx;
        end
    end

    assign bus.Ins_Req  = ins_req;
    assign bus.Ins_Addr = PC;
    assign bus.Mem_Req  = mem_req;
    assign bus.Mem_RW   = mem_rw;
    assign Alu_En       = alu_en;
    assign Reg_WE       = reg_we;
    assign Halted       = (state == HALT);
    assign Busy         = (state != IDLE) && (state != HALT);
    assign Dbg_State    = state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: instruction/data RAM responders with
// programmable ack delay, a per-cycle monitor and a fetch-address scoreboard.
module tb_cpu_sequencer;
    import cpu_pkg::*;

    localparam int ADDR_W = 16;

    logic              Clk = 1'b0;
    logic              Reset_n;
    logic              Run;
    logic [31:0]       Instr;
    logic              Alu_En;
    logic [3:0]        New_Flag;
    logic [3:0]        Flag;
    logic              Reg_WE;
    logic [ADDR_W-1:0] PC;
    logic              Halted;
    logic              Busy;
    state_t            Dbg_State;

    cpu_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    cpu_sequencer #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (16'h0000)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Run       (Run),
        .bus       (bus),
        .Instr     (Instr),
        .Alu_En    (Alu_En),
        .New_Flag  (New_Flag),
        .Flag      (Flag),
        .Reg_WE    (Reg_WE),
        .PC        (PC),
        .Halted    (Halted),
        .Busy      (Busy),
        .Dbg_State (Dbg_State)
    );

    // ---------------- clock ----------------
    always #5 Clk = ~Clk;

    // ---------------- memories / responders ----------------
    logic [31:0] imem [0:63];
    int          ins_delay     = 0;
    int          mem_delay     = 0;
    logic        force_ins_ack = 1'b0;
    logic        force_mem_ack = 1'b0;

    initial begin : ins_responder
        int   cnt;
        logic real_ack;
        cnt          = 0;
        bus.Ins_Ack  = 1'b0;
        bus.Ins_Data = '0;
        forever begin
            @(negedge Clk);
            real_ack = 1'b0;
            if (bus.Ins_Req === 1'b1) begin
                if (cnt >= ins_delay) begin
                    real_ack = 1'b1;
                    cnt      = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
            bus.Ins_Ack  = real_ack | force_ins_ack;
            bus.Ins_Data = real_ack ? imem[bus.Ins_Addr[5:0]] : 32'hDEAD_BEEF;
        end
    end

    initial begin : mem_responder
        int   cnt;
        logic real_ack;
        cnt         = 0;
        bus.Mem_Ack = 1'b0;
        forever begin
            @(negedge Clk);
            real_ack = 1'b0;
            if (bus.Mem_Req === 1'b1) begin
                if (cnt >= mem_delay) begin
                    real_ack = 1'b1;
                    cnt      = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
            bus.Mem_Ack = real_ack | force_mem_ack;
        end
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor + fetch scoreboard ----------------
    int          cyc;
    int          we_cnt;
    int          first_we;
    int          halt_cyc;
    int          alu_cnt;
    int          mem_req_cnt;
    logic        rw_high_seen;
    logic        rw_low_seen;
    logic        prev_ins_req;
    logic        sb_on;
    int          sb_extra;
    logic [15:0] exp_q[$];

    task automatic clear_mon();
        cyc          = 0;
        we_cnt       = 0;
        first_we     = -1;
        halt_cyc     = -1;
        alu_cnt      = 0;
        mem_req_cnt  = 0;
        rw_high_seen = 1'b0;
        rw_low_seen  = 1'b0;
        prev_ins_req = 1'b0;
        sb_on        = 1'b0;
        sb_extra     = 0;
        exp_q.delete();
    endtask

    // One clock: sample outputs 2 time units after the rising edge
    task automatic tick();
        logic [15:0] e;
        @(posedge Clk);
        #2;
        cyc++;
        if (Reg_WE) begin
            we_cnt++;
            if (first_we < 0) first_we = cyc;
        end
        if (Alu_En) alu_cnt++;
        if (bus.Mem_Req) begin
            mem_req_cnt++;
            if (bus.Mem_RW) rw_high_seen = 1'b1;
            else            rw_low_seen  = 1'b1;
        end
        if (Halted && halt_cyc < 0) halt_cyc = cyc;
        if (sb_on && bus.Ins_Req && !prev_ins_req) begin
            if (exp_q.size() == 0) begin
                sb_extra++;
            end else begin
                e = exp_q.pop_front();
                check("fetch_addr", bus.Ins_Addr, e);
            end
        end
        prev_ins_req = bus.Ins_Req;
    endtask

    task automatic run_until_halt(input int limit);
        int n;
        n = 0;
        while (!Halted && n < limit) begin
            tick();
            n++;
        end
        check("halt_reached", Halted, 1'b1);
    endtask

    task automatic do_reset();
        Run           = 1'b0;
        Reset_n       = 1'b0;
        force_ins_ack = 1'b0;
        force_mem_ack = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        clear_mon();
    endtask

    function automatic logic [31:0] enc(input logic [3:0] c, input logic [3:0] op,
                                        input logic s, input logic [15:0] iv);
        return {c, op, s, 4'b0000, iv, 3'b000};
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = enc(COND_AL, OP_HALT, 1'b0, 16'h0);
    endtask

    // ---------------- condition table ----------------
    typedef struct {
        logic [3:0] cond;
        logic [3:0] flag;   // {N,Z,C,V} loaded by the preceding S=1 op
        logic       exec;
    } cond_vec_t;

    cond_vec_t vecs[14];

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vecs[0]  = '{COND_EQ, 4'b0100, 1'b1};
        vecs[1]  = '{COND_NE, 4'b0100, 1'b0};
        vecs[2]  = '{COND_CS, 4'b0010, 1'b1};
        vecs[3]  = '{COND_MI, 4'b0000, 1'b0};
        vecs[4]  = '{COND_VS, 4'b0001, 1'b1};
        vecs[5]  = '{COND_HI, 4'b0010, 1'b1};
        vecs[6]  = '{COND_LS, 4'b0010, 1'b0};
        vecs[7]  = '{COND_GE, 4'b1001, 1'b1};
        vecs[8]  = '{COND_LT, 4'b1000, 1'b1};
        vecs[9]  = '{COND_GT, 4'b0100, 1'b0};
        vecs[10] = '{COND_LE, 4'b0000, 1'b0};
        vecs[11] = '{COND_NV, 4'b0000, 1'b0};
        vecs[12] = '{COND_CC, 4'b0010, 1'b0};
        vecs[13] = '{COND_PL, 4'b1000, 1'b0};

        New_Flag = 4'h0;
        clear_imem();

        // ---- reset state ----
        do_reset();
        #1;
        check("rst_state",   Dbg_State, IDLE);
        check("rst_pc",      PC, 16'h0000);
        check("rst_instr",   Instr, 32'h0);
        check("rst_flag",    Flag, 4'h0);
        check("rst_ins_req", bus.Ins_Req, 1'b0);
        check("rst_mem_req", bus.Mem_Req, 1'b0);
        check("rst_alu_en",  Alu_En, 1'b0);
        check("rst_reg_we",  Reg_WE, 1'b0);
        check("rst_mem_rw",  bus.Mem_RW, 1'b1);
        check("rst_halted",  Halted, 1'b0);
        check("rst_busy",    Busy, 1'b0);

        // ---- acks while IDLE are ignored ----
        force_ins_ack = 1'b1;
        force_mem_ack = 1'b1;
        repeat (3) tick();
        check("idle_ack_state", Dbg_State, IDLE);
        check("idle_ack_instr", Instr, 32'h0);
        force_ins_ack = 1'b0;
        force_mem_ack = 1'b0;

        // ---- ALU op then HALT, zero-wait; S=0 must not touch flags ----
        clear_imem();
        imem[0] = enc(COND_AL, 4'h1, 1'b0, 16'h0);
        New_Flag = 4'hF;
        do_reset();
        Run = 1'b1;
        run_until_halt(30);
        check("alu_first_we", first_we, 4);
        check("alu_we_cnt",   we_cnt, 1);
        check("alu_halt_cyc", halt_cyc, 7);
        check("alu_halt_pc",  PC, 16'h0001);
        check("alu_en_cnt",   alu_cnt, 2);
        check("alu_flag_s0",  Flag, 4'h0);
        check("halt_busy",    Busy, 1'b0);

        // ---- same program with a spurious Mem_Ack held high throughout ----
        force_mem_ack = 1'b1;
        do_reset();
        force_mem_ack = 1'b1;
        Run = 1'b1;
        run_until_halt(30);
        check("spur_mem_first_we", first_we, 4);
        check("spur_mem_halt_cyc", halt_cyc, 7);
        check("spur_mem_req_cnt",  mem_req_cnt, 0);
        force_mem_ack = 1'b0;

        // ---- delayed instruction ack: Req held 4 cycles, no early latch ----
        ins_delay = 3;
        do_reset();
        Run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("dly_ins_req",   bus.Ins_Req, 1'b1);
            check("dly_instr_old", Instr, 32'h0);
        end
        tick();
        check("dly_decode",  Dbg_State, DECODE);
        check("dly_req_off", bus.Ins_Req, 1'b0);
        check("dly_instr",   Instr, enc(COND_AL, 4'h1, 1'b0, 16'h0));
        run_until_halt(40);
        check("dly_first_we", first_we, 7);
        check("dly_halt_cyc", halt_cyc, 13);
        ins_delay = 0;

        // ---- condition-code table ----
        for (int r = 0; r < 14; r++) begin
            clear_imem();
            imem[0] = enc(COND_AL, 4'h2, 1'b1, 16'h0);
            imem[1] = enc(vecs[r].cond, 4'h3, 1'b0, 16'h0);
            New_Flag = vecs[r].flag;
            do_reset();
            Run = 1'b1;
            run_until_halt(40);
            check($sformatf("cc%0d_flag", r),     Flag, vecs[r].flag);
            check($sformatf("cc%0d_we_cnt", r),   we_cnt, vecs[r].exec ? 2 : 1);
            check($sformatf("cc%0d_halt_cyc", r), halt_cyc, vecs[r].exec ? 11 : 9);
            check($sformatf("cc%0d_pc", r),       PC, 16'h0002);
        end

        // ---- LDR with Mem_Ack after 2 wait cycles; S=1 ignored ----
        clear_imem();
        imem[0] = enc(COND_AL, OP_LDR, 1'b1, 16'h0);
        New_Flag  = 4'hA;
        mem_delay = 2;
        do_reset();
        Run = 1'b1;
        run_until_halt(40);
        check("ldr_mem_req_cnt", mem_req_cnt, 3);
        check("ldr_rw_read",     rw_high_seen, 1'b1);
        check("ldr_rw_write",    rw_low_seen, 1'b0);
        check("ldr_first_we",    first_we, 7);
        check("ldr_we_cnt",      we_cnt, 1);
        check("ldr_alu_cnt",     alu_cnt, 5);
        check("ldr_halt_cyc",    halt_cyc, 10);
        check("ldr_flag",        Flag, 4'h0);

        // ---- same LDR with Ins_Ack forced high during MEM/WRITEBACK ----
        do_reset();
        force_ins_ack = 1'b1;
        Run = 1'b1;
        run_until_halt(40);
        check("spur_ins_first_we", first_we, 7);
        check("spur_ins_halt_cyc", halt_cyc, 10);
        check("spur_ins_we_cnt",   we_cnt, 1);
        force_ins_ack = 1'b0;

        // ---- STR, zero-wait ----
        clear_imem();
        imem[0]   = enc(COND_AL, OP_STR, 1'b0, 16'h0);
        mem_delay = 0;
        do_reset();
        Run = 1'b1;
        run_until_halt(40);
        check("str_mem_req_cnt", mem_req_cnt, 1);
        check("str_rw_write",    rw_low_seen, 1'b1);
        check("str_rw_read",     rw_high_seen, 1'b0);
        check("str_we_cnt",      we_cnt, 0);
        check("str_halt_cyc",    halt_cyc, 7);
        check("str_pc",          PC, 16'h0001);

        // ---- branch to 5, then HALT restart on Run low->high ----
        clear_imem();
        imem[0] = enc(COND_AL, 4'h1, 1'b0, 16'h0);
        imem[1] = enc(COND_AL, 4'h2, 1'b0, 16'h0);
        imem[2] = enc(COND_AL, OP_B, 1'b1, 16'h0005);
        imem[3] = enc(COND_AL, 4'h3, 1'b0, 16'h0);
        New_Flag = 4'hF;
        do_reset();
        sb_on = 1'b1;
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0002);
        exp_q.push_back(16'h0005);
        Run = 1'b1;
        run_until_halt(40);
        check("br_halt_cyc", halt_cyc, 14);
        check("br_pc",       PC, 16'h0005);
        check("br_we_cnt",   we_cnt, 2);
        check("br_flag",     Flag, 4'h0);
        check("br_sb_left",  exp_q.size(), 0);
        check("br_sb_extra", sb_extra, 0);
        repeat (3) tick();
        check("halt_hold_run1", Halted, 1'b1);
        check("halt_hold_pc",   PC, 16'h0005);
        Run = 1'b0;
        repeat (2) tick();
        check("halt_hold_run0", Halted, 1'b1);
        exp_q.push_back(16'h0006);
        Run      = 1'b1;
        halt_cyc = -1;
        cyc      = 0;
        tick();
        check("restart_fetch", Dbg_State, FETCH);
        run_until_halt(20);
        check("restart_halt_cyc", halt_cyc, 3);
        check("restart_pc",       PC, 16'h0006);
        check("restart_sb_left",  exp_q.size(), 0);
        check("restart_sb_extra", sb_extra, 0);

        // ---- PC wrap: branch to FFFF, ALU op wraps to 0, EQ HALT there ----
        clear_imem();
        imem[0]  = enc(COND_EQ, OP_HALT, 1'b0, 16'h0);
        imem[1]  = enc(COND_AL, 4'h4, 1'b1, 16'h0);
        imem[2]  = enc(COND_AL, OP_B, 1'b0, 16'hFFFF);
        imem[63] = enc(COND_AL, 4'h5, 1'b0, 16'h0);
        New_Flag = 4'b0100;
        do_reset();
        sb_on = 1'b1;
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0002);
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'h0000);
        Run = 1'b1;
        run_until_halt(60);
        check("wrap_halt_cyc", halt_cyc, 16);
        check("wrap_pc",       PC, 16'h0000);
        check("wrap_we_cnt",   we_cnt, 2);
        check("wrap_flag",     Flag, 4'b0100);
        check("wrap_sb_left",  exp_q.size(), 0);
        check("wrap_sb_extra", sb_extra, 0);

        // ---- Run dropped mid-instruction: finish it, then IDLE ----
        clear_imem();
        imem[0] = enc(COND_AL, 4'h1, 1'b0, 16'h0);
        imem[1] = enc(COND_AL, 4'h2, 1'b0, 16'h0);
        do_reset();
        Run = 1'b1;
        tick();
        tick();
        Run = 1'b0;
        repeat (3) tick();
        check("stop_state",  Dbg_State, IDLE);
        check("stop_busy",   Busy, 1'b0);
        check("stop_pc",     PC, 16'h0001);
        check("stop_we_cnt", we_cnt, 1);
        repeat (2) tick();
        check("stop_stays_idle", Dbg_State, IDLE);
        Run = 1'b1;
        tick();
        check("resume_req",  bus.Ins_Req, 1'b1);
        check("resume_addr", bus.Ins_Addr, 16'h0001);

        // ---- reset asserted while a data access is pending ----
        clear_imem();
        imem[0]   = enc(COND_AL, 4'h1, 1'b1, 16'h0);
        imem[1]   = enc(COND_AL, OP_LDR, 1'b0, 16'h0);
        New_Flag  = 4'hF;
        mem_delay = 20;
        do_reset();
        Run = 1'b1;
        begin
            int n;
            n = 0;
            while (!bus.Mem_Req && n < 30) begin
                tick();
                n++;
            end
        end
        check("mid_mem_req_up", bus.Mem_Req, 1'b1);
        check("mid_flag_set",   Flag, 4'hF);
        #1;
        Reset_n = 1'b0;
        #1;
        check("mid_rst_mem_req", bus.Mem_Req, 1'b0);
        check("mid_rst_alu_en",  Alu_En, 1'b0);
        check("mid_rst_reg_we",  Reg_WE, 1'b0);
        check("mid_rst_busy",    Busy, 1'b0);
        Run = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        #1;
        check("mid_rel_state", Dbg_State, IDLE);
        check("mid_rel_pc",    PC, 16'h0000);
        check("mid_rel_flag",  Flag, 4'h0);
        check("mid_rel_we",    we_cnt, 1);
        mem_delay = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
